// File: rtl/timer_pkg.sv
// ============================================================================
// timer_pkg : tick-interface constants and monitor state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2
  } mon_state_e;

  // Shared with the countdown timer so both ends agree on the tick rate.
  localparam int unsigned TICK_PERIOD_DEFAULT = 40;
  localparam int unsigned TICK_WIDTH_DEFAULT  = 26;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rise_detect.sv
// ============================================================================
// rise_detect : registers the tick input and flags its rising edge
// Rev 1.0
// ============================================================================
`default_nettype none

module rise_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pulse_i,
  output logic accept_o
);

  logic pulse_d_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pulse_d_q <= 1'b0;
    end else begin
      pulse_d_q <= pulse_i;
    end
  end

  assign accept_o = pulse_i & ~pulse_d_q;

endmodule

`default_nettype wire

// File: rtl/pulse_period_monitor.sv
// ============================================================================
// pulse_period_monitor : measures tick spacing, flags early/late/missing ticks
// Rev 1.0
// ============================================================================
`default_nettype none

module pulse_period_monitor
  import timer_pkg::*;
#(
  parameter int unsigned EXPECTED_PERIOD = TICK_PERIOD_DEFAULT,
  parameter int unsigned TOLERANCE       = 0,
  parameter int unsigned TIMEOUT_CYCLES  = 2 * EXPECTED_PERIOD,
  parameter int unsigned WIDTH           = TICK_WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             pulse_i,
  output logic [WIDTH-1:0] period_o,
  output logic             period_valid_o,
  output logic             early_o,
  output logic             late_o,
  output logic             missing_o,
  output logic             locked_o,
  output logic [7:0]       err_count_o
);

  localparam logic [WIDTH-1:0] LO_BOUND  = WIDTH'(EXPECTED_PERIOD - TOLERANCE);
  localparam logic [WIDTH-1:0] HI_BOUND  = WIDTH'(EXPECTED_PERIOD + TOLERANCE);
  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

  if (TOLERANCE >= EXPECTED_PERIOD) begin : g_bad_tolerance
    $error("pulse_period_monitor: TOLERANCE must be below EXPECTED_PERIOD");
  end
  if (TIMEOUT_CYCLES <= EXPECTED_PERIOD + TOLERANCE) begin : g_bad_timeout
    $error("pulse_period_monitor: TIMEOUT_CYCLES must exceed EXPECTED_PERIOD+TOLERANCE");
  end

  mon_state_e       state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] period_q;
  logic             period_valid_q;
  logic             early_q;
  logic             late_q;
  logic             missing_q;
  logic [1:0]       good_run_q;
  logic [1:0]       good_run_d;
  logic [7:0]       err_count_q;
  logic [7:0]       err_count_d;
  logic             accept;
  logic             is_early;
  logic             is_late;

  rise_detect u_rise_detect (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .pulse_i  (pulse_i),
    .accept_o (accept)
  );

  // The one compare pair; only consulted when a tick closes an interval.
  assign is_early    = (count_q < LO_BOUND);
  assign is_late     = (count_q > HI_BOUND);
  assign good_run_d  = (good_run_q == 2'd2) ? 2'd2 : good_run_q + 2'd1;
  assign err_count_d = sat_inc8(err_count_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      count_q        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      early_q        <= 1'b0;
      late_q         <= 1'b0;
      missing_q      <= 1'b0;
      good_run_q     <= 2'd0;
      err_count_q    <= 8'd0;
    end else begin
      period_valid_q <= 1'b0;
      early_q        <= 1'b0;
      late_q         <= 1'b0;
      missing_q      <= 1'b0;
      if (!enable_i) begin
        // Dropping enable outranks a tick arriving in the same cycle.
        state_q    <= IDLE;
        count_q    <= '0;
        good_run_q <= 2'd0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= WAIT_FIRST;
          end
          WAIT_FIRST: begin
            if (accept) begin
              state_q <= MEASURE;
              count_q <= ONE_W;
            end
          end
          MEASURE: begin
            if (accept) begin
              period_q       <= count_q;
              period_valid_q <= 1'b1;
              early_q        <= is_early;
              late_q         <= is_late;
              count_q        <= ONE_W;
              if (is_early || is_late) begin
                good_run_q  <= 2'd0;
                err_count_q <= err_count_d;
              end else begin
                good_run_q  <= good_run_d;
              end
            end else if (count_q == TIMEOUT_W) begin
              missing_q   <= 1'b1;
              state_q     <= WAIT_FIRST;
              count_q     <= '0;
              good_run_q  <= 2'd0;
              err_count_q <= err_count_d;
            end else begin
              count_q <= count_q + ONE_W;
            end
          end
          default: begin
            state_q <= IDLE;
            count_q <= '0;
          end
        endcase
      end
    end
  end

  assign period_o       = period_q;
  assign period_valid_o = period_valid_q;
  assign early_o        = early_q;
  assign late_o         = late_q;
  assign missing_o      = missing_q;
  assign locked_o       = (good_run_q == 2'd2);
  assign err_count_o    = err_count_q;

endmodule

`default_nettype wire
